// File: rtl/modexp_ladder_par.sv
// Montgomery-ladder modular exponentiation controller (x^e mod m) driving two external MM units.
// Build option: define CONST_TIME_EN to remove leading-zero skipping so latency depends only on lene.
module modexp_ladder_par #(
    parameter int WIDTH = 1024,
    parameter int LEN_W = 11
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0] in_r,
    input  logic [WIDTH-1:0] in_r2,
    input  logic [LEN_W-1:0] lene,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             mul1_start,
    output logic [WIDTH-1:0] mul1_a,
    output logic [WIDTH-1:0] mul1_b,
    input  logic             mul1_done,
    input  logic [WIDTH-1:0] mul1_res,
    output logic             mul2_start,
    output logic [WIDTH-1:0] mul2_a,
    input  logic             mul2_done,
    input  logic [WIDTH-1:0] mul2_res
);

    localparam int               IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_TOMONT,
        S_TOMONT_W,
`ifndef CONST_TIME_EN
        S_SKIP,
`endif
        S_ISSUE,
        S_WAIT,
        S_FROM,
        S_FROM_W,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [LEN_W-1:0] idx, idx_n;
    logic             d1, d1_n;
    logic             d2, d2_n;
    logic             lene_zero;
    logic             ld_xx, ld_ladder, ld_result;

    logic [WIDTH-1:0] x_q, e_q, r2_q, a_q, xx_q, res1_q, res2_q;
    logic [LEN_W-1:0] lene_c;
    logic             e_bit;
    logic             accept;

    assign lene_c = (lene > WIDTH_L) ? WIDTH_L : lene;
    assign e_bit  = e_q[idx[IDX_W-1:0]];
    assign accept = (state == S_IDLE) && start;
    assign busy   = (state != S_IDLE) && (state != S_DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            idx       <= '0;
            d1        <= 1'b0;
            d2        <= 1'b0;
            lene_zero <= 1'b0;
            result    <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            d1    <= d1_n;
            d2    <= d2_n;
            if (accept)
                lene_zero <= (lene_c == '0);
            if (ld_result)
                result <= mul1_res;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        d1_n       = d1;
        d2_n       = d2;
        ld_xx      = 1'b0;
        ld_ladder  = 1'b0;
        ld_result  = 1'b0;
        done       = 1'b0;
        mul1_start = 1'b0;
        mul2_start = 1'b0;
        case (state)
            S_IDLE: begin
                d1_n = 1'b0;
                d2_n = 1'b0;
                if (start) begin
                    idx_n   = lene_c - ONE_L;
                    state_n = S_TOMONT;
                end
            end
            S_TOMONT: begin
                mul1_start = 1'b1;
                state_n    = S_TOMONT_W;
            end
            S_TOMONT_W: begin
                if (mul1_done) begin
                    ld_xx = 1'b1;
                    if (lene_zero)
                        state_n = S_FROM;
                    else
`ifdef CONST_TIME_EN
                        state_n = S_ISSUE;
`else
                        state_n = S_SKIP;
`endif
                end
            end
`ifndef CONST_TIME_EN
            S_SKIP: begin
                // Bit 0 always reaches ISSUE even when clear: a zero bit still squares A correctly.
                if (!e_bit && (idx != '0))
                    idx_n = idx - ONE_L;
                else
                    state_n = S_ISSUE;
            end
`endif
            S_ISSUE: begin
                mul1_start = 1'b1;
                mul2_start = 1'b1;
                d1_n       = 1'b0;
                d2_n       = 1'b0;
                state_n    = S_WAIT;
            end
            S_WAIT: begin
                d1_n = d1 | mul1_done;
                d2_n = d2 | mul2_done;
                if (d1 && d2) begin
                    ld_ladder = 1'b1;
                    if (idx == '0) begin
                        state_n = S_FROM;
                    end else begin
                        idx_n   = idx - ONE_L;
                        state_n = S_ISSUE;
                    end
                end
            end
            S_FROM: begin
                mul1_start = 1'b1;
                state_n    = S_FROM_W;
            end
            S_FROM_W: begin
                if (mul1_done) begin
                    ld_result = 1'b1;
                    state_n   = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Operands are pure functions of state and held registers, so they stay stable until done.
    always_comb begin
        mul1_a = a_q;
        mul1_b = xx_q;
        case (state)
            S_TOMONT, S_TOMONT_W: begin
                mul1_a = x_q;
                mul1_b = r2_q;
            end
            S_FROM, S_FROM_W: begin
                mul1_a = a_q;
                mul1_b = ONE_W;
            end
            default: begin
                mul1_a = a_q;
                mul1_b = xx_q;
            end
        endcase
    end

    assign mul2_a = e_bit ? xx_q : a_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            x_q  <= in_x;
            e_q  <= in_e;
            r2_q <= in_r2;
            a_q  <= in_r;
        end
        if (ld_xx)
            xx_q <= mul1_res;
        if ((state == S_WAIT) && mul1_done && !d1)
            res1_q <= mul1_res;
        if ((state == S_WAIT) && mul2_done && !d2)
            res2_q <= mul2_res;
        // Ladder step: the product always lands in the register selected by the inverse of the bit.
        if (ld_ladder) begin
            if (e_bit) begin
                a_q  <= res1_q;
                xx_q <= res2_q;
            end else begin
                xx_q <= res1_q;
                a_q  <= res2_q;
            end
        end
    end

endmodule
